// File: rtl/wb_spm_pkg.sv
// wb_spm_pkg: register map and bit positions shared by the SPM MAC wrapper and core.
package wb_spm_pkg;
  typedef enum logic [7:0] {
    OFS_X      = 8'h00,
    OFS_Y      = 8'h04,
    OFS_CTRL   = 8'h08,
    OFS_STATUS = 8'h0C,
    OFS_P_LO   = 8'h10,
    OFS_P_HI   = 8'h14
  } reg_ofs_e;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ACC    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CLR    = 3;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  function automatic logic [31:0] wmask(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = sel[i] ? dat[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/wb_spm_mac_if.sv
// wb_spm_mac_if: Caravel wishbone slave bus bundle.
interface wb_spm_mac_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport slave (input wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                 output wbs_ack_o, wbs_dat_o);
  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/spm_core.sv
// spm_core: serial shift-add multiplier, one multiplier bit per clock.
module spm_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               acc_in,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] p_in,
  output logic               busy,
  output logic               done_pulse,
  output logic [2*WIDTH-1:0] p_out
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  logic [PW-1:0]    xs, sum;
  logic [WIDTH-1:0] ys;
  logic [CW-1:0]    cnt;
  // p_out is the next partial sum, so the wrapper can capture it on the final busy edge
  assign p_out      = sum + (ys[0] ? xs : '0);
  assign done_pulse = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      xs   <= '0;
      ys   <= '0;
      cnt  <= '0;
      sum  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      xs   <= PW'(x);
      ys   <= y;
      cnt  <= '0;
      sum  <= acc_in ? p_in : '0;
    end else if (busy) begin
      busy <= !done_pulse;
      xs   <= xs << 1;
      ys   <= ys >> 1;
      cnt  <= cnt + 1'b1;
      sum  <= p_out;
    end
  end
endmodule

// File: rtl/wb_spm_mac.sv
// wb_spm_mac: wishbone register file and decode around the serial multiply-accumulate core.
module wb_spm_mac
  import wb_spm_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  wb_spm_mac_if.slave  wb,
  output logic         irq
);
  localparam int PW = 2 * WIDTH;
  logic [WIDTH-1:0] x, y;
  logic [PW-1:0]    p, p_out, p_seed;
  logic [63:0]      p64;
  logic [31:0]      rdata, dat;
  logic [7:0]       ofs;
  logic acc, irq_en, done, busy, done_pulse;
  logic hit, wr, wr_ctrl, start, clr, acc_d, w1c;
  assign dat     = wb.wbs_dat_i;
  assign ofs     = wb.wbs_adr_i[7:0];
  assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wb.wbs_ack_o;
  assign wr      = hit & wb.wbs_we_i;
  assign wr_ctrl = wr & (ofs == OFS_CTRL) & wb.wbs_sel_i[0];
  assign start   = wr_ctrl & dat[CTRL_START] & ~busy;
  assign clr     = wr_ctrl & dat[CTRL_CLR] & ~busy;
  assign w1c     = wr & (ofs == OFS_STATUS) & wb.wbs_sel_i[0] & dat[STATUS_DONE];
  // ACC written alongside START takes effect for that run; CLR beats an accumulate seed
  assign acc_d   = wr_ctrl ? dat[CTRL_ACC] : acc;
  assign p_seed  = clr ? '0 : p;
  assign p64     = 64'(p);
  always_comb
    rdata = ofs == OFS_X      ? 32'(x) :
            ofs == OFS_Y      ? 32'(y) :
            ofs == OFS_CTRL   ? 32'({irq_en, acc, 1'b0}) :
            ofs == OFS_STATUS ? 32'({done, busy}) :
            ofs == OFS_P_LO   ? p64[31:0] :
            ofs == OFS_P_HI   ? p64[63:32] : 32'h0;
  spm_core #(.WIDTH(WIDTH)) u_core (
    .clk(wb_clk_i), .rst(wb_rst_i), .start, .acc_in(acc_d), .x, .y, .p_in(p_seed),
    .busy, .done_pulse, .p_out
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      irq          <= 1'b0;
      x            <= '0;
      y            <= '0;
      p            <= '0;
      acc          <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
    end else begin
      wb.wbs_ack_o <= hit;
      wb.wbs_dat_o <= (hit & ~wb.wbs_we_i) ? rdata : '0;
      irq          <= done & irq_en;
      if (wr && ofs == OFS_X && !busy) x <= WIDTH'(wmask(32'(x), dat, wb.wbs_sel_i));
      if (wr && ofs == OFS_Y && !busy) y <= WIDTH'(wmask(32'(y), dat, wb.wbs_sel_i));
      if (wr_ctrl) begin
        acc    <= dat[CTRL_ACC];
        irq_en <= dat[CTRL_IRQ_EN];
      end
      if (clr) p <= '0;
      else if (done_pulse) p <= p_out;
      if (done_pulse) done <= 1'b1;
      else if (start || w1c) done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_spm_mac.sv
// tb_wb_spm_mac: randomized bus traffic against a transaction-level MAC model, plus directed literals.
module tb_wb_spm_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq32, irq8;
  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  localparam logic [31:0] BASE = 32'h3000_0000;

  wb_spm_mac_if i32();
  wb_spm_mac_if i8();
  wb_spm_mac #(.WIDTH(32), .BASE_ADDR(BASE)) dut32 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(i32), .irq(irq32));
  wb_spm_mac #(.WIDTH(8),  .BASE_ADDR(BASE)) dut8  (.wb_clk_i(clk), .wb_rst_i(rst), .wb(i8),  .irq(irq8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction

  // Model of the 32-bit instance: the product is plain arithmetic, only timing is counted in cycles
  logic [31:0] mx, my, m_dat;
  logic [63:0] mp, pend;
  bit macc, mien, mdone, m_ack, m_irq;
  int bl;
  always @(posedge clk) begin
    logic [31:0] d, rdv;
    logic [7:0] o;
    logic [3:0] s;
    bit hit, wr, busy, wc, st, cl;
    if (rst) begin
      mx = 0; my = 0; mp = 0; pend = 0; macc = 0; mien = 0; mdone = 0;
      m_ack = 0; m_dat = 0; m_irq = 0; bl = 0;
    end else begin
      d = i32.wbs_dat_i; o = i32.wbs_adr_i[7:0]; s = i32.wbs_sel_i;
      hit = i32.wbs_cyc_i && i32.wbs_stb_i && i32.wbs_adr_i[31:8] == BASE[31:8] && !m_ack;
      busy = bl > 0;
      case (o)
        8'h00: rdv = mx;
        8'h04: rdv = my;
        8'h08: rdv = {29'b0, mien, macc, 1'b0};
        8'h0C: rdv = {30'b0, mdone, busy};
        8'h10: rdv = mp[31:0];
        8'h14: rdv = mp[63:32];
        default: rdv = 0;
      endcase
      m_irq = mdone && mien;
      m_ack = hit;
      m_dat = (hit && !i32.wbs_we_i) ? rdv : 32'h0;
      wr = hit && i32.wbs_we_i;
      if (wr && o == 8'h00 && !busy) mx = merge(mx, d, s);
      if (wr && o == 8'h04 && !busy) my = merge(my, d, s);
      wc = wr && o == 8'h08 && s[0];
      st = wc && d[0] && !busy;
      cl = wc && d[3] && !busy;
      if (wc) begin macc = d[1]; mien = d[2]; end
      if (cl) mp = 0;
      if ((wr && o == 8'h0C && s[0] && d[1]) || st) mdone = 0;
      if (busy) begin
        bl--;
        if (bl == 0) begin mp = pend; mdone = 1; end
      end
      if (st) begin
        pend = (macc ? mp : 64'h0) + 64'(mx) * 64'(my);
        bl = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ack", 64'(i32.wbs_ack_o), 64'(m_ack));
      chk("dat", 64'(i32.wbs_dat_o), 64'(m_dat));
      chk("irq", 64'(irq32), 64'(m_irq));
    end
  end

  task automatic bus(input bit b8, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output bit ok);
    ok = 0; r = 0;
    @(negedge clk);
    if (b8) begin
      i8.wbs_cyc_i = 1; i8.wbs_stb_i = 1; i8.wbs_we_i = w; i8.wbs_adr_i = a; i8.wbs_dat_i = d; i8.wbs_sel_i = s;
    end else begin
      i32.wbs_cyc_i = 1; i32.wbs_stb_i = 1; i32.wbs_we_i = w; i32.wbs_adr_i = a; i32.wbs_dat_i = d; i32.wbs_sel_i = s;
    end
    for (int k = 0; k < 4 && !ok; k++) begin
      @(negedge clk);
      if (b8 ? i8.wbs_ack_o : i32.wbs_ack_o) begin
        ok = 1;
        r = b8 ? i8.wbs_dat_o : i32.wbs_dat_o;
      end
    end
    i8.wbs_cyc_i = 0; i8.wbs_stb_i = 0; i8.wbs_we_i = 0;
    i32.wbs_cyc_i = 0; i32.wbs_stb_i = 0; i32.wbs_we_i = 0;
  endtask

  task automatic wr(input bit b8, input logic [7:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r;
    bit ok;
    bus(b8, 1, BASE | 32'(o), d, s, r, ok);
  endtask

  task automatic rd(input bit b8, input logic [7:0] o, output logic [31:0] r);
    bit ok;
    bus(b8, 0, BASE | 32'(o), 0, 4'hF, r, ok);
  endtask

  task automatic wait_idle(input bit b8);
    logic [31:0] r;
    int n = 0;
    do begin rd(b8, 8'h0C, r); n++; end while (r[0] && n < 60);
    chk("busy_timeout", 64'(r[0]), 64'h0);
  endtask

  initial begin
    logic [31:0] r;
    bit ok;
    {i32.wbs_cyc_i, i32.wbs_stb_i, i32.wbs_we_i} = 0; i32.wbs_sel_i = 0; i32.wbs_adr_i = 0; i32.wbs_dat_i = 0;
    {i8.wbs_cyc_i, i8.wbs_stb_i, i8.wbs_we_i} = 0; i8.wbs_sel_i = 0; i8.wbs_adr_i = 0; i8.wbs_dat_i = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    checking = 1;
    rd(0, 8'h00, r); chk("rst_x", 64'(r), 0);
    rd(0, 8'h0C, r); chk("rst_status", 64'(r), 0);
    rd(0, 8'h10, r); chk("rst_plo", 64'(r), 0);
    // full-scale product and exact busy window
    wr(0, 8'h00, 32'hFFFF_FFFF);
    wr(0, 8'h04, 32'hFFFF_FFFF);
    wr(0, 8'h08, 32'h1);
    repeat (29) @(negedge clk);
    rd(0, 8'h0C, r); chk("busy_last_cycle", 64'(r), 64'h1);
    rd(0, 8'h0C, r); chk("done_after_32", 64'(r), 64'h2);
    rd(0, 8'h14, r); chk("max_phi", 64'(r), 64'hFFFF_FFFE);
    rd(0, 8'h10, r); chk("max_plo", 64'(r), 64'h1);
    // accumulate
    wr(0, 8'h08, 32'hA);
    wr(0, 8'h00, 3); wr(0, 8'h04, 5); wr(0, 8'h08, 32'h3); wait_idle(0);
    wr(0, 8'h00, 7); wr(0, 8'h04, 2); wr(0, 8'h08, 32'h3); wait_idle(0);
    rd(0, 8'h10, r); chk("acc_plo", 64'(r), 64'h1D);
    rd(0, 8'h14, r); chk("acc_phi", 64'(r), 0);
    // writes during busy are ignored
    wr(0, 8'h08, 0);
    wr(0, 8'h00, 2); wr(0, 8'h04, 4); wr(0, 8'h08, 32'h1);
    bus(0, 1, BASE, 32'h55, 4'hF, r, ok); chk("busy_write_ack", 64'(ok), 1);
    rd(0, 8'h00, r); chk("busy_x_kept", 64'(r), 2);
    wait_idle(0);
    rd(0, 8'h10, r); chk("busy_plo", 64'(r), 8);
    // interrupt and decode
    wr(0, 8'h08, 32'h4);
    wr(0, 8'h00, 2); wr(0, 8'h04, 3); wr(0, 8'h08, 32'h5); wait_idle(0);
    @(negedge clk); chk("irq_set", 64'(irq32), 1);
    wr(0, 8'h0C, 32'h2);
    @(negedge clk); chk("irq_clear", 64'(irq32), 0);
    rd(0, 8'h0C, r); chk("done_w1c", 64'(r), 0);
    bus(0, 0, BASE | 32'h18, 0, 4'hF, r, ok); chk("unmapped_ack", 64'(ok), 1); chk("unmapped_dat", 64'(r), 0);
    bus(0, 0, 32'h3000_0100, 0, 4'hF, r, ok); chk("out_window_noack", 64'(ok), 0);
    // reset mid-run
    wr(0, 8'h00, 32'h1234_5678); wr(0, 8'h04, 32'h9ABC_DEF0); wr(0, 8'h08, 32'h5);
    repeat (5) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    chk("rst_irq", 64'(irq32), 0);
    rd(0, 8'h0C, r); chk("rst_mid_status", 64'(r), 0);
    rd(0, 8'h10, r); chk("rst_mid_plo", 64'(r), 0);
    wr(0, 8'h00, 9); wr(0, 8'h04, 11); wr(0, 8'h08, 32'h1); wait_idle(0);
    rd(0, 8'h10, r); chk("after_rst_plo", 64'(r), 99);
    // random traffic against the model
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 5))
        0: wr(0, 8'h00, $urandom, 4'($urandom));
        1: wr(0, 8'h04, $urandom, 4'($urandom));
        2: wr(0, 8'h08, $urandom & 32'hF, 4'($urandom));
        3: wr(0, 8'h0C, $urandom & 32'h3, 4'($urandom));
        4: rd(0, 8'($urandom_range(0, 7) * 4), r);
        default: repeat ($urandom_range(0, 40)) @(negedge clk);
      endcase
    end
    wait_idle(0);
    // narrow build
    wr(1, 8'h00, 32'hFF); wr(1, 8'h04, 32'h2); wr(1, 8'h08, 32'h1); wait_idle(1);
    rd(1, 8'h10, r); chk("w8_plo", 64'(r), 64'h1FE);
    rd(1, 8'h14, r); chk("w8_phi", 64'(r), 0);
    wr(1, 8'h00, 32'h0);
    wr(1, 8'h00, 32'h1FF, 4'b0011);
    rd(1, 8'h00, r); chk("w8_x_trunc", 64'(r), 64'hFF);
    wr(1, 8'h00, 32'h5A5A_5A00);
    rd(1, 8'h00, r); chk("w8_x_upper_drop", 64'(r), 0);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
